// File: rtl/markov_transition_sampler.sv
// Two-pass weighted sampler over a {note, count} list in RAM: sum the counts, scale the random word, then cumulative search.
// Optional internal 16-bit LFSR random source when MARKOV_SAMPLER_LFSR_EN is defined.
module markov_transition_sampler #(
    parameter int NOTE_W = 7,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 6,
    parameter int RAND_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_start,
    input  logic [ADDR_W-1:0]       i_list_base,
    input  logic [ADDR_W:0]         i_list_len,
    input  logic [RAND_W-1:0]       i_rand_in,
    output logic                    o_mem_rd,
    output logic [ADDR_W-1:0]       o_mem_addr,
    input  logic [NOTE_W+CNT_W-1:0] i_mem_rdata,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [NOTE_W-1:0]       o_next_note
);

    localparam int TOT_W  = CNT_W + ADDR_W + 1;
    localparam int PROD_W = RAND_W + TOT_W;

    typedef enum logic [2:0] {
        IDLE,
        SUM,
        SCALE,
        SEARCH,
        FINISH
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W:0]     r_len;
    logic [RAND_W-1:0]   r_rand;
    logic [ADDR_W:0]     r_idx;
    logic                r_rvalid;
    logic [TOT_W-1:0]    r_total;
    logic [TOT_W-1:0]    r_cum;
    logic [TOT_W-1:0]    r_thresh;
    logic                r_error;
    logic [NOTE_W-1:0]   r_note;

    logic [CNT_W-1:0]    w_count;
    logic [NOTE_W-1:0]   w_note;
    logic [TOT_W-1:0]    w_cum_next;
    logic                w_more;
    logic                w_hit;
    logic [PROD_W-1:0]   w_product;
    logic [TOT_W-1:0]    w_thresh;
    logic [RAND_W-1:0]   w_rand_src;

    assign w_count    = i_mem_rdata[CNT_W-1:0];
    assign w_note     = i_mem_rdata[NOTE_W+CNT_W-1:CNT_W];
    assign w_cum_next = r_cum + TOT_W'(w_count);
    assign w_more     = (r_idx < r_len);
    assign w_hit      = (r_state == SEARCH) && r_rvalid && (w_cum_next > r_thresh);
    assign w_product  = PROD_W'(r_rand) * PROD_W'(r_total);
    assign w_thresh   = TOT_W'(w_product >> RAND_W);

`ifdef MARKOV_SAMPLER_LFSR_EN
    logic [15:0] r_lfsr;
    logic        w_lfsr_fb;

    // Taps 16,14,13,11 in right-shift Fibonacci form; stepped once per accepted start.
    assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign w_rand_src = RAND_W'(r_lfsr);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= 16'hACE1;
        end else if (r_state == IDLE && i_start) begin
            r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
        end
    end
`else
    assign w_rand_src = i_rand_in;
`endif

    assign o_mem_addr  = r_base + r_idx[ADDR_W-1:0];
    assign o_busy      = (r_state == SUM) || (r_state == SCALE) || (r_state == SEARCH);
    assign o_done      = (r_state == FINISH);
    assign o_error     = (r_state == FINISH) && r_error;
    assign o_next_note = r_note;

    // An empty list goes through SCALE, where the cleared total flags the error one cycle later.
    always_comb begin
        w_state_next = r_state;
        o_mem_rd     = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_state_next = (i_list_len == '0) ? SCALE : SUM;
                end
            end
            SUM: begin
                o_mem_rd = w_more;
                if (!w_more && r_rvalid) begin
                    w_state_next = SCALE;
                end
            end
            SCALE: begin
                w_state_next = (r_total == '0) ? FINISH : SEARCH;
            end
            SEARCH: begin
                o_mem_rd = w_more && !w_hit;
                if (w_hit || (!w_more && !r_rvalid)) begin
                    w_state_next = FINISH;
                end
            end
            FINISH: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_base   <= '0;
            r_len    <= '0;
            r_rand   <= '0;
            r_idx    <= '0;
            r_rvalid <= 1'b0;
            r_total  <= '0;
            r_cum    <= '0;
            r_thresh <= '0;
            r_error  <= 1'b0;
            r_note   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rvalid <= o_mem_rd;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_base  <= i_list_base;
                        r_len   <= i_list_len;
                        r_rand  <= w_rand_src;
                        r_total <= '0;
                        r_cum   <= '0;
                        r_idx   <= '0;
                        r_error <= 1'b0;
                    end
                end
                SUM: begin
                    if (o_mem_rd) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    if (r_rvalid) begin
                        r_total <= r_total + TOT_W'(w_count);
                    end
                end
                SCALE: begin
                    r_thresh <= w_thresh;
                    r_idx    <= '0;
                    r_cum    <= '0;
                    if (r_total == '0) begin
                        r_error <= 1'b1;
                    end
                end
                SEARCH: begin
                    if (o_mem_rd) begin
                        r_idx <= r_idx + 1'b1;
                    end
                    if (r_rvalid) begin
                        r_cum <= w_cum_next;
                    end
                    // Exhausting the list without a hit cannot happen while threshold < total.
                    if (w_hit) begin
                        r_note <= w_note;
                    end else if (!w_more && !r_rvalid) begin
                        r_error <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_markov_transition_sampler.sv
// Directed bench for markov_transition_sampler with a behavioural one-cycle-latency list RAM.
// The MARKOV_SAMPLER_LFSR_EN build swaps the rand_in-driven vectors for LFSR-sequence vectors.
module tb_markov_transition_sampler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  listBase = '0;
    logic [6:0]  listLen = '0;
    logic [15:0] randIn = '0;
    logic        memRd;
    logic [5:0]  memAddr;
    logic [14:0] memRdata = '0;
    logic        busy;
    logic        done;
    logic        error;
    logic [6:0]  nextNote;

    logic [14:0] mem [0:63];
    int          rdCount = 0;
    int          addrLog [0:1023];

    int checkCount = 0;
    int passCount = 0;
    int failCount = 0;

    int lastNote;
    int lastErr;
    int busyAtOne;
    int busyAtDone;
    int doneCycle;
    int readCount;
    int extraDone;
    int logBase;

    markov_transition_sampler dut (
        .clk        (clk),
        .reset      (reset),
        .i_start    (start),
        .i_list_base(listBase),
        .i_list_len (listLen),
        .i_rand_in  (randIn),
        .o_mem_rd   (memRd),
        .o_mem_addr (memAddr),
        .i_mem_rdata(memRdata),
        .o_busy     (busy),
        .o_done     (done),
        .o_error    (error),
        .o_next_note(nextNote)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memRd) begin
            memRdata <= mem[memAddr];
            if (rdCount < 1024) begin
                addrLog[rdCount] <= int'(memAddr);
            end
            rdCount <= rdCount + 1;
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Start accepted at the posedge after the first negedge (cycle 0); cycles are counted on negedges.
    task automatic applyStimulus(input logic [5:0] base, input logic [6:0] len,
                                 input logic [15:0] rnd, input bit spam);
        int startReads;
        @(negedge clk);
        listBase   = base;
        listLen    = len;
        randIn     = rnd;
        start      = 1'b1;
        startReads = rdCount;
        @(negedge clk);
        doneCycle = 1;
        busyAtOne = int'(busy);
        if (spam) begin
            listBase = 6'd5;
            listLen  = 7'd1;
            randIn   = 16'h0000;
        end else begin
            start = 1'b0;
        end
        while (!done && doneCycle < 200) begin
            @(negedge clk);
            doneCycle++;
        end
        start = 1'b0;
        checkOutput("doneSeen", int'(done), 1);
        lastNote   = int'(nextNote);
        lastErr    = int'(error);
        busyAtDone = int'(busy);
        readCount  = rdCount - startReads;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        mem[0]  = {7'd60, 8'd1};
        mem[1]  = {7'd62, 8'd2};
        mem[2]  = {7'd64, 8'd1};
        mem[62] = {7'd10, 8'd0};
        mem[63] = {7'd20, 8'd5};
        mem[10] = {7'd90, 8'd0};
        mem[11] = {7'd91, 8'd0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rstBusy", int'(busy), 0);
        checkOutput("rstDone", int'(done), 0);
        checkOutput("rstError", int'(error), 0);
        checkOutput("rstNote", int'(nextNote), 0);
        checkOutput("rstMemRd", int'(memRd), 0);
        checkOutput("rstMemAddr", int'(memAddr), 0);
        reset = 1'b0;

`ifdef MARKOV_SAMPLER_LFSR_EN
        // 16'hACE1 -> threshold 2; successor 16'h5670 -> threshold 1; total 4.
        applyStimulus(6'd0, 7'd3, 16'hFFFF, 1'b0);
        checkOutput("lfsr1Note", lastNote, 62);
        checkOutput("lfsr1Cycle", doneCycle, 9);
        applyStimulus(6'd0, 7'd3, 16'h0000, 1'b0);
        checkOutput("lfsr2Note", lastNote, 62);
        checkOutput("lfsr2Cycle", doneCycle, 9);
`else
        applyStimulus(6'd0, 7'd3, 16'h0000, 1'b0);
        checkOutput("r0Note", lastNote, 60);
        checkOutput("r0Err", lastErr, 0);
        checkOutput("r0Cycle", doneCycle, 8);
        checkOutput("r0BusyAt1", busyAtOne, 1);
        checkOutput("r0BusyAtDone", busyAtDone, 0);

        applyStimulus(6'd0, 7'd3, 16'h4000, 1'b0);
        checkOutput("r4000Note", lastNote, 62);
        checkOutput("r4000Cycle", doneCycle, 9);

        applyStimulus(6'd0, 7'd3, 16'hC000, 1'b0);
        checkOutput("rC000Note", lastNote, 64);
        checkOutput("rC000Cycle", doneCycle, 10);

        applyStimulus(6'd0, 7'd3, 16'hFFFF, 1'b0);
        checkOutput("rFFFFNote", lastNote, 64);
        checkOutput("rFFFFErr", lastErr, 0);

        applyStimulus(6'd0, 7'd3, 16'hC000, 1'b1);
        checkOutput("spamNote", lastNote, 64);
        checkOutput("spamCycle", doneCycle, 10);
        extraDone = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) extraDone++;
        end
        checkOutput("spamExtraDone", extraDone, 0);

        @(negedge clk);
        listBase = 6'd0;
        listLen  = 7'd3;
        randIn   = 16'hC000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("midBusy", int'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstMidBusy", int'(busy), 0);
        checkOutput("rstMidDone", int'(done), 0);
        checkOutput("rstMidNote", int'(nextNote), 0);
        reset = 1'b0;
        applyStimulus(6'd0, 7'd3, 16'h4000, 1'b0);
        checkOutput("afterRstNote", lastNote, 62);
        checkOutput("afterRstCycle", doneCycle, 9);
`endif

        logBase = rdCount;
        applyStimulus(6'd62, 7'd3, 16'h0000, 1'b0);
        checkOutput("wrapNote", lastNote, 20);
        checkOutput("wrapErr", lastErr, 0);
        checkOutput("wrapCycle", doneCycle, 9);
        checkOutput("wrapAddr0", addrLog[logBase], 62);
        checkOutput("wrapAddr1", addrLog[logBase + 1], 63);
        checkOutput("wrapAddr2", addrLog[logBase + 2], 0);

        applyStimulus(6'd7, 7'd0, 16'h1234, 1'b0);
        checkOutput("len0Err", lastErr, 1);
        checkOutput("len0Cycle", doneCycle, 2);
        checkOutput("len0Reads", readCount, 0);
        checkOutput("len0Note", lastNote, 20);

        applyStimulus(6'd10, 7'd2, 16'h8000, 1'b0);
        checkOutput("zeroErr", lastErr, 1);
        checkOutput("zeroCycle", doneCycle, 5);
        checkOutput("zeroNote", lastNote, 20);

        @(negedge clk);
        checkOutput("idleMemRd", int'(memRd), 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
